cache_fill_ctrl: RTL and testbench
==================================

Name: cache_fill_ctrl

Overview:
- Lookup, LRU and miss-fill sequencer for the 2-way set-associative cache: 64 sets × 2 ways, 16-byte blocks.
- Reads the per-way metadata bytes of the addressed set and resolves hit/miss.
- Maintains a 1-bit LRU per set and drives the metadata write strobes (one shared write-data bus, one write enable per way).
- On a miss, streams an 8-word block from memory into the data array.
- Sits between the pipeline's memory stage and the metadata/data arrays plus main memory.

Parameters:
- SETS, 64, number of sets; set_en width; index width = log2(SETS) = 6
- WORDS, 8, 16-bit words per block; word offset = addr[3:1]
- TAG_W, 6, tag bits = addr[15:10]

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-low
- req_valid  in  1  access request; held stable by requester while stall=1
- req_addr  in  16  byte address: tag [15:10], index [9:4], word [3:1]
- meta_rd0  in  8  way-0 metadata of enabled set: [7] valid, [6] LRU flag, [5:0] tag
- meta_rd1  in  8  way-1 metadata; [6] unused, written 0
- set_en  out  64  one-hot set select = decode(req_addr[9:4]); all zero when req_valid=0 and IDLE
- meta_wdata  out  8  metadata write data
- meta_we0  out  1  write way-0 metadata
- meta_we1  out  1  write way-1 metadata
- hit  out  1  request satisfied this cycle
- hit_way  out  1  way that hit; valid only when hit=1
- stall  out  1  requester must hold
- mem_req  out  1  one word read request to memory
- mem_addr  out  16  word address {tag,index,word,1'b0}
- mem_data_valid  in  1  in-order read return strobe
- data_we  out  1  write returned word into data array
- data_word_en  out  8  one-hot word select for data_we
- data_way  out  1  victim way for fill

Behaviour:
- Reset (rst=0, async): state=IDLE, counters=0. All outputs 0, including set_en. Metadata contents are untouched; the array resets itself. Reset mid-fill abandons the fill; late mem_data_valid after release is ignored in IDLE.
- LRU encoding: meta0[6]=1 means way 0 is the victim; meta0[6]=0 means way 1 is the victim.
- Reads must never coincide with a metadata write: array outputs float while a way is written. No compare occurs in any cycle with meta_we0|meta_we1=1.
- IDLE:
  - If req_valid: hitN = metaN[7] & (metaN[5:0]==tag). hit = hit0|hit1; hit_way = hit1. If both ways match, way 0 wins.
  - On a hit, if meta0[6] already equals hit_way, no LRU write; stay IDLE (back-to-back hits, 1/cycle). Otherwise go to UPD.
  - On a miss: hit=0, stall=1. Latch tag/index/meta0. Victim = way 0 if !v0, else way 1 if !v1, else meta0[6] ? 0 : 1. Go to FILL.
- UPD (1 cycle): meta_we0=1, meta_wdata = {meta0[7], hit_way, meta0[5:0]}; stall=1 for any req. Then IDLE.
- FILL:
  - issue_cnt 0..7: mem_req=1 for 8 consecutive cycles with mem_addr word = issue_cnt.
  - rx_cnt counts mem_data_valid; each strobe gives data_we=1, data_word_en=1<<rx_cnt, data_way=victim. Issue and receive may overlap. Independent of memory latency.
  - mem_data_valid before any issue is ignored.
  - When the 8th word is received, go to META.
- META (1 cycle): write victim way {1'b1, lru, tag}.
  - Victim 0: lru=0, so way 1 becomes victim; then IDLE.
  - Victim 1: lru=0 in way1's unused bit; then LRU.
- LRU (1 cycle, victim-1 path only): meta_we0=1, meta_wdata = {latched meta0[7], 1'b1, latched meta0[5:0]}; then IDLE.
- In IDLE the held request re-compares and hits.
- stall = 1 in every non-IDLE state, and in IDLE when req_valid & ~hit.

Optional Feature:
- CRIT_WORD_FIRST_EN defined: the fill issue order starts at the requested word and wraps mod 8 (word w, w+1, …, 7, 0, …, w-1). data_word_en follows the same order. Block completion rules are unchanged.
- Undefined: issue order is always 0..7.

Test Plan:
- Reset, then req addr 0x1230 on empty set 0x23 -> miss; victim way 0; mem_addr 0x1230-0x123E words 0..7 on 8 cycles; after 8 returns, meta_we0 with wdata 0x84; next IDLE cycle hit=1, hit_way=0.
- Same set, tag 0x05 (addr 0x1630) after step 1 -> victim way 1; META meta_we1 wdata 0x85, then LRU meta_we0 wdata 0xC4; replay hits way 1.
- Set full (way0 tag 4 LRU=1) -> access tag 4: hit way 0, UPD writes 0x84; next hit on way 0 needs no UPD, hits on consecutive cycles.
- Third tag 0x07 to the full set with meta0[6]=0 -> victim way 1 replaced (meta1=0x87), meta0[6]=1.
- Assert rst=0 mid-FILL after 3 returns -> all outputs 0 immediately; after release, no mem_req until a new miss.
- CRIT_WORD_FIRST_EN, miss at addr 0x123A -> mem_addr words 5,6,7,0,1,2,3,4; data_word_en 0x20,0x40,0x80,0x01, ….

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: lookup, 1-bit LRU and miss-fill sequencer for a 2-way
// set-associative cache (64 sets, 8 x 16-bit words per block).
// Optional feature macro: CRIT_WORD_FIRST_EN - when defined, the fill starts
// at the requested word and wraps around the block; otherwise words 0..7.
module cache_fill_ctrl #(
  parameter int SETS  = 64,
  parameter int WORDS = 8,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [15:0]      req_addr,
  input  logic [7:0]       meta_rd0,
  input  logic [7:0]       meta_rd1,
  output logic [SETS-1:0]  set_en,
  output logic [7:0]       meta_wdata,
  output logic             meta_we0,
  output logic             meta_we1,
  output logic             hit,
  output logic             hit_way,
  output logic             stall,
  output logic             mem_req,
  output logic [15:0]      mem_addr,
  input  logic             mem_data_valid,
  output logic             data_we,
  output logic [WORDS-1:0] data_word_en,
  output logic             data_way
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WRD_W = $clog2(WORDS);
  localparam int CNT_W = WRD_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_UPD, S_FILL, S_META, S_LRU} state_t;

  state_t           state_reg, state_next;
  logic [TAG_W-1:0] tag_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       meta0_reg;
  logic             victim_reg;
  logic             hit_way_reg;
  logic [WRD_W-1:0] start_reg;
  logic [CNT_W-1:0] issue_cnt_reg;
  logic [CNT_W-1:0] rx_cnt_reg;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [WRD_W-1:0] req_word;
  logic             lookup, hit0, hit1, hit_any, hit_sel, need_upd, victim_sel;
  logic             issue_go, rx_ok, rx_last;
  logic [WRD_W-1:0] issue_word, rx_word;
  logic [IDX_W-1:0] set_sel;
  logic [SETS-1:0]  set_dec;
  logic [WORDS-1:0] word_dec;

  // Way-1 LRU bit is never read and the byte-lane address bit has no meaning here.
  logic unused_bits;
  assign unused_bits = ^{meta_rd1[6], req_addr[0]};

  assign req_tag  = req_addr[15 -: TAG_W];
  assign req_idx  = req_addr[4 +: IDX_W];
  assign req_word = req_addr[1 +: WRD_W];

  // Tag compare only happens in IDLE, where no metadata write is ever driven.
  assign lookup     = (state_reg == S_IDLE) && req_valid;
  assign hit0       = meta_rd0[7] && (meta_rd0[TAG_W-1:0] == req_tag);
  assign hit1       = meta_rd1[7] && (meta_rd1[TAG_W-1:0] == req_tag);
  assign hit_any    = hit0 | hit1;
  assign hit_sel    = hit1 & ~hit0;
  assign need_upd   = hit_any && (meta_rd0[6] != hit_sel);
  // Empty ways are filled first; otherwise the LRU flag in way 0 picks.
  assign victim_sel = !meta_rd0[7] ? 1'b0 : (!meta_rd1[7] ? 1'b1 : ~meta_rd0[6]);

  // A return strobe is only accepted once a matching request has gone out.
  assign issue_go = (state_reg == S_FILL) && (issue_cnt_reg < CNT_W'(WORDS));
  assign rx_ok    = (state_reg == S_FILL) && mem_data_valid && (rx_cnt_reg < issue_cnt_reg);
  assign rx_last  = rx_ok && (rx_cnt_reg == CNT_W'(WORDS - 1));

`ifdef CRIT_WORD_FIRST_EN
  assign issue_word = issue_cnt_reg[WRD_W-1:0] + start_reg;
  assign rx_word    = rx_cnt_reg[WRD_W-1:0] + start_reg;
`else
  assign issue_word = issue_cnt_reg[WRD_W-1:0];
  assign rx_word    = rx_cnt_reg[WRD_W-1:0];
`endif

  // IDLE follows the live request; every other state works on the latched set.
  assign set_sel = (state_reg == S_IDLE) ? req_idx : idx_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_set_dec
      assign set_dec[gi] = (set_sel == IDX_W'(gi));
    end
    for (gi = 0; gi < WORDS; gi++) begin : g_word_dec
      assign word_dec[gi] = (rx_word == WRD_W'(gi));
    end
  endgenerate

  // State register plus the miss/update context captured at lookup time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      tag_reg       <= '0;
      idx_reg       <= '0;
      meta0_reg     <= '0;
      victim_reg    <= 1'b0;
      hit_way_reg   <= 1'b0;
      start_reg     <= '0;
      issue_cnt_reg <= '0;
      rx_cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (lookup && !hit_any) begin
        tag_reg       <= req_tag;
        idx_reg       <= req_idx;
        meta0_reg     <= meta_rd0;
        victim_reg    <= victim_sel;
        start_reg     <= req_word;
        issue_cnt_reg <= '0;
        rx_cnt_reg    <= '0;
      end else if (lookup && need_upd) begin
        idx_reg     <= req_idx;
        meta0_reg   <= meta_rd0;
        hit_way_reg <= hit_sel;
      end
      if (issue_go) issue_cnt_reg <= issue_cnt_reg + 1'b1;
      if (rx_ok)    rx_cnt_reg    <= rx_cnt_reg + 1'b1;
    end
  end

  // Next-state and output decode; all outputs are held low while reset is asserted.
  always_comb begin
    state_next   = state_reg;
    set_en       = '0;
    meta_wdata   = '0;
    meta_we0     = 1'b0;
    meta_we1     = 1'b0;
    hit          = 1'b0;
    hit_way      = 1'b0;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    data_we      = 1'b0;
    data_word_en = '0;
    data_way     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          set_en  = set_dec;
          hit     = hit_any;
          hit_way = hit_sel;
          if (!hit_any) begin
            stall      = 1'b1;
            state_next = S_FILL;
          end else if (need_upd) begin
            state_next = S_UPD;
          end
        end
      end
      S_UPD: begin
        set_en     = set_dec;
        stall      = 1'b1;
        meta_we0   = 1'b1;
        meta_wdata = {meta0_reg[7], hit_way_reg, meta0_reg[5:0]};
        state_next = S_IDLE;
      end
      S_FILL: begin
        set_en  = set_dec;
        stall   = 1'b1;
        mem_req = issue_go;
        if (issue_go) mem_addr = {tag_reg, idx_reg, issue_word, 1'b0};
        data_we = rx_ok;
        if (rx_ok) begin
          data_word_en = word_dec;
          data_way     = victim_reg;
        end
        if (rx_last) state_next = S_META;
      end
      S_META: begin
        set_en     = set_dec;
        stall      = 1'b1;
        meta_we0   = ~victim_reg;
        meta_we1   = victim_reg;
        meta_wdata = {1'b1, 1'b0, tag_reg};
        state_next = victim_reg ? S_LRU : S_IDLE;
      end
      S_LRU: begin
        set_en     = set_dec;
        stall      = 1'b1;
        meta_we0   = 1'b1;
        meta_wdata = {meta0_reg[7], 1'b1, meta0_reg[5:0]};
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (!rst) begin
      set_en       = '0;
      meta_wdata   = '0;
      meta_we0     = 1'b0;
      meta_we1     = 1'b0;
      hit          = 1'b0;
      hit_way      = 1'b0;
      stall        = 1'b0;
      mem_req      = 1'b0;
      mem_addr     = '0;
      data_we      = 1'b0;
      data_word_en = '0;
      data_way     = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: scoreboard bench for cache_fill_ctrl with a metadata
// array model and a fixed-latency memory model.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  meta_rd0, meta_rd1;
  logic [63:0] set_en;
  logic [7:0]  meta_wdata;
  logic        meta_we0, meta_we1, hit, hit_way, stall, mem_req;
  logic [15:0] mem_addr;
  logic        mem_data_valid;
  logic        data_we;
  logic [7:0]  data_word_en;
  logic        data_way;
  logic        stray = 1'b0;
  logic        mon_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cache_fill_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .meta_rd0(meta_rd0), .meta_rd1(meta_rd1), .set_en(set_en),
    .meta_wdata(meta_wdata), .meta_we0(meta_we0), .meta_we1(meta_we1),
    .hit(hit), .hit_way(hit_way), .stall(stall), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data_valid(mem_data_valid), .data_we(data_we),
    .data_word_en(data_word_en), .data_way(data_way)
  );

  // Metadata array model: combinational read of the enabled set, write on clock.
  logic [7:0] m0_arr [64] = '{default: 8'h00};
  logic [7:0] m1_arr [64] = '{default: 8'h00};
  logic [5:0] sel_idx;
  logic       sel_ok;

  always_comb begin
    sel_idx = '0;
    sel_ok  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (set_en[i]) begin
        sel_idx = 6'(i);
        sel_ok  = 1'b1;
      end
    end
  end

  assign meta_rd0 = sel_ok ? m0_arr[sel_idx] : 8'h00;
  assign meta_rd1 = sel_ok ? m1_arr[sel_idx] : 8'h00;

  always @(posedge clk) begin
    if (sel_ok && meta_we0) m0_arr[sel_idx] <= meta_wdata;
    if (sel_ok && meta_we1) m1_arr[sel_idx] <= meta_wdata;
  end

  // Memory model: every request returns a strobe three cycles later, in order.
  logic [2:0] pipe = '0;
  always @(posedge clk) pipe <= {pipe[1:0], mem_req};
  assign mem_data_valid = pipe[2] | stray;

  // Scoreboard queues
  logic [15:0] exp_mem_q  [$];
  logic [8:0]  exp_dwe_q  [$];
  logic [15:0] exp_meta_q [$];
  logic [6:0]  exp_hit_q  [$];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_fill(input logic [15:0] addr, input logic way);
    logic [2:0] w;
    for (int i = 0; i < 8; i++) begin
`ifdef CRIT_WORD_FIRST_EN
      w = addr[3:1] + 3'(i);
`else
      w = 3'(i);
`endif
      exp_mem_q.push_back({addr[15:4], w, 1'b0});
      exp_dwe_q.push_back({way, 8'd1 << w});
    end
  endtask

  task automatic expect_meta(input logic [5:0] set, input logic we1, input logic we0,
                             input logic [7:0] wdata);
    exp_meta_q.push_back({set, we1, we0, wdata});
  endtask

  task automatic expect_hit(input logic [5:0] set, input logic way);
    exp_hit_q.push_back({set, way});
  endtask

  // Pops and compares whatever the DUT produced this cycle.
  task automatic monitor_step();
    logic [15:0] m;
    logic [8:0]  d;
    logic [6:0]  h;
    if (mem_req) begin
      if (exp_mem_q.size() == 0) chk_val("mem_req_unexpected", 32'(mem_req), 32'd0);
      else begin
        m = exp_mem_q.pop_front();
        chk_val("mem_addr", 32'(mem_addr), 32'(m));
      end
    end
    if (data_we) begin
      if (exp_dwe_q.size() == 0) chk_val("data_we_unexpected", 32'(data_we), 32'd0);
      else begin
        d = exp_dwe_q.pop_front();
        chk_val("data_wr", 32'({data_way, data_word_en}), 32'(d));
      end
    end
    if (meta_we0 || meta_we1) begin
      chk_val("set_en_onehot", 32'($countones(set_en)), 32'd1);
      if (exp_meta_q.size() == 0) chk_val("meta_we_unexpected", 32'({meta_we1, meta_we0}), 32'd0);
      else begin
        m = exp_meta_q.pop_front();
        chk_val("meta_wr", 32'({sel_idx, meta_we1, meta_we0, meta_wdata}), 32'(m));
      end
    end
    if (hit) begin
      if (exp_hit_q.size() == 0) chk_val("hit_unexpected", 32'(hit), 32'd0);
      else begin
        h = exp_hit_q.pop_front();
        chk_val("hit", 32'({sel_idx, hit_way}), 32'(h));
      end
    end
  endtask

  // Presents one request (called at posedge+1) until the DUT stops stalling.
  task automatic access(input logic [15:0] addr, output int cycles);
    req_valid = 1'b1;
    req_addr  = addr;
    cycles    = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (stall && cycles < 200);
    if (stall) chk_val("access_timeout", 32'(stall), 32'd0);
    $display("access addr=0x%04h cycles=%0d", addr, cycles);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_val(tag, 32'({|set_en, stall, mem_req, hit, hit_way, meta_we0, meta_we1,
                      data_we, data_way, |mem_addr, |data_word_en, |meta_wdata}), 32'd0);
  endtask

  initial begin
    int cyc;
    int n;
    int k;
    int cnt_req;
    int cnt_dwe;

    fork
      forever begin
        @(negedge clk);
        if (rst && mon_en) monitor_step();
      end
    join_none

    // Reset: outputs low even with a request presented.
    repeat (2) @(negedge clk);
    chk_all_zero("reset_idle_outputs");
    req_valid = 1'b1;
    req_addr  = 16'h1230;
    #1;
    chk_all_zero("reset_with_req_outputs");
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    @(negedge clk);
    chk_val("idle_set_en", 32'(|set_en), 32'd0);
    chk_val("idle_stall", 32'(stall), 32'd0);

    // Stray strobe while idle must not write the data array.
    @(posedge clk);
    #1;
    stray = 1'b1;
    @(negedge clk);
    chk_val("stray_strobe_ignored", 32'(data_we), 32'd0);
    @(posedge clk);
    #1;
    stray = 1'b0;

    // Miss on empty set 0x23, tag 4: victim way 0.
    expect_fill(16'h1230, 1'b0);
    expect_meta(6'h23, 1'b0, 1'b1, 8'h84);
    expect_hit(6'h23, 1'b0);
    access(16'h1230, cyc);

    // Tag 5 to the same set: victim way 1, then LRU update.
    expect_fill(16'h1630, 1'b1);
    expect_meta(6'h23, 1'b1, 1'b0, 8'h85);
    expect_meta(6'h23, 1'b0, 1'b1, 8'hC4);
    expect_hit(6'h23, 1'b1);
    access(16'h1630, cyc);

    // Hit way 0 with LRU pointing at way 0: one update, then 1/cycle hits.
    expect_hit(6'h23, 1'b0);
    expect_meta(6'h23, 1'b0, 1'b1, 8'h84);
    access(16'h1230, cyc);
    chk_val("hit_upd_cycles", 32'(cyc), 32'd1);
    expect_hit(6'h23, 1'b0);
    access(16'h1230, cyc);
    chk_val("hit_after_upd_cycles", 32'(cyc), 32'd2);
    expect_hit(6'h23, 1'b0);
    access(16'h1230, cyc);
    chk_val("b2b_hit_cycles_a", 32'(cyc), 32'd1);
    expect_hit(6'h23, 1'b0);
    access(16'h1230, cyc);
    chk_val("b2b_hit_cycles_b", 32'(cyc), 32'd1);

    // Third tag 7 to the full set with meta0[6]=0: replace way 1.
    expect_fill(16'h1E30, 1'b1);
    expect_meta(6'h23, 1'b1, 1'b0, 8'h87);
    expect_meta(6'h23, 1'b0, 1'b1, 8'hC4);
    expect_hit(6'h23, 1'b1);
    access(16'h1E30, cyc);
    expect_hit(6'h23, 1'b1);
    access(16'h1E30, cyc);
    chk_val("replay_way1_cycles", 32'(cyc), 32'd1);

    // Miss with a non-zero word offset (set 0x24, word 5).
    expect_fill(16'h124A, 1'b0);
    expect_meta(6'h24, 1'b0, 1'b1, 8'h84);
    expect_hit(6'h24, 1'b0);
    access(16'h124A, cyc);
    req_valid = 1'b0;

    // Reset in the middle of a fill, after three returns.
    expect_fill(16'h2450, 1'b0);
    req_valid = 1'b1;
    req_addr  = 16'h2450;
    n = 0;
    k = 0;
    while (n < 3 && k < 100) begin
      @(negedge clk);
      k++;
      if (data_we) n++;
    end
    chk_val("rst_fill_returns", 32'(n), 32'd3);
    #1;
    rst = 1'b0;
    #1;
    chk_all_zero("mid_fill_reset_outputs");
    exp_mem_q.delete();
    exp_dwe_q.delete();
    exp_meta_q.delete();
    exp_hit_q.delete();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cnt_req = 0;
    cnt_dwe = 0;
    repeat (12) begin
      @(negedge clk);
      if (mem_req) cnt_req++;
      if (data_we) cnt_dwe++;
    end
    chk_val("no_mem_req_after_rst", 32'(cnt_req), 32'd0);
    chk_val("late_strobes_ignored", 32'(cnt_dwe), 32'd0);
    @(posedge clk);
    #1;

    // New miss to the abandoned set starts a complete fill from scratch.
    expect_fill(16'h2450, 1'b0);
    expect_meta(6'h05, 1'b0, 1'b1, 8'h89);
    expect_hit(6'h05, 1'b0);
    access(16'h2450, cyc);
    req_valid = 1'b0;

    repeat (5) @(negedge clk);
    chk_val("mem_q_drained", 32'(exp_mem_q.size()), 32'd0);
    chk_val("dwe_q_drained", 32'(exp_dwe_q.size()), 32'd0);
    chk_val("meta_q_drained", 32'(exp_meta_q.size()), 32'd0);
    chk_val("hit_q_drained", 32'(exp_hit_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
